// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. Sits between the PPU line buffer
// and the board VGA DAC pins: it walks the horizontal/vertical raster, tells
// the line buffer which address it needs next, and turns the RGB555 pixel it
// gets back into registered sync and colour outputs.
//
// Ports:
//   clk           pixel clock
//   reset_n       asynchronous active-low reset
//   sync          synchronous frame restart, active high (wins over everything)
//   border        draw a full-intensity frame on the active-area edges
//   scan_en       dim odd active lines (scanline effect)
//   pixel         RGB555 for this cycle: R=[4:0], G=[9:5], B=[14:10]
//   vga_h, vga_v  registered hsync / vsync, active level HS_POL / VS_POL
//   vga_r/g/b     registered colour, COLOR_BITS per channel, 1-cycle latency
//   hcount        current horizontal counter
//   vcount        current vertical counter
//   next_pixel_x  ping-pong line-buffer address needed on the next cycle:
//                 MSB selects the buffer half, low LB_AW bits the pixel
//   blank         high outside the active area (combinational from counters)
//   frame_start   one-cycle pulse the cycle after the raster sat at (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE   = 512,
    parameter int H_FP       = 58,
    parameter int H_SYNC     = 82,
    parameter int H_BP       = 30,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 32,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int COLOR_BITS = 4,
    parameter int LB_AW      = 9
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sync,
    input  logic                  border,
    input  logic                  scan_en,
    input  logic [14:0]           pixel,
    output logic                  vga_h,
    output logic                  vga_v,
    output logic [COLOR_BITS-1:0] vga_r,
    output logic [COLOR_BITS-1:0] vga_g,
    output logic [COLOR_BITS-1:0] vga_b,
    output logic [9:0]            hcount,
    output logic [9:0]            vcount,
    output logic [LB_AW:0]        next_pixel_x,
    output logic                  blank,
    output logic                  frame_start
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] H_EDGE   = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_EDGE   = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic       HS_ON    = (HS_POL != 0);
    localparam logic       VS_ON    = (VS_POL != 0);

    logic [9:0] h;
    logic [9:0] v;
    logic       line_sel;
    logic       hend;
    logic       vend;
    logic [9:0] new_h;
    logic       ptr_msb;
    logic       on_edge;

    logic [COLOR_BITS-1:0] r_n;
    logic [COLOR_BITS-1:0] g_n;
    logic [COLOR_BITS-1:0] b_n;

    // The lowest bits of each 5-bit field are dropped when COLOR_BITS < 5.
    logic unused_pixel_bits;
    assign unused_pixel_bits = ^pixel;

    assign hend  = (h == H_LAST);
    assign vend  = (v == V_LAST);
    assign new_h = (hend || sync) ? 10'd0 : h + 10'd1;

    // The line buffer half flips at the end of each line, so the address
    // for the first pixel of the next line already points at the other half.
    assign ptr_msb      = sync ? 1'b0 : (hend ? ~line_sel : line_sel);
    assign next_pixel_x = {ptr_msb, new_h[LB_AW-1:0]};

    assign hcount = h;
    assign vcount = v;
    assign blank  = !((h < H_VIS) && (v < V_VIS));

    assign on_edge = (h == 10'd0) || (h == H_EDGE) || (v == 10'd0) || (v == V_EDGE);

    // Colour stages in rising priority: truncate, scanline dim, border, blank.
    always_comb begin
        r_n = pixel[4 -: COLOR_BITS];
        g_n = pixel[9 -: COLOR_BITS];
        b_n = pixel[14 -: COLOR_BITS];
        if (scan_en && v[0]) begin
            r_n = r_n >> 1;
            g_n = g_n >> 1;
            b_n = b_n >> 1;
        end
        if (border && on_edge) begin
            r_n = '1;
            g_n = '1;
            b_n = '1;
        end
        if (blank) begin
            r_n = '0;
            g_n = '0;
            b_n = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h           <= 10'd0;
            v           <= 10'd0;
            line_sel    <= 1'b0;
            vga_h       <= ~HS_ON;
            vga_v       <= ~VS_ON;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            frame_start <= 1'b0;
        end else begin
            h <= new_h;

            if (sync) begin
                v        <= 10'd0;
                line_sel <= 1'b0;
            end else if (hend) begin
                v        <= vend ? 10'd0 : v + 10'd1;
                line_sel <= ~line_sel;
            end

            // Sync outputs only change on exact counter matches, so a restart
            // can only ever drive them inactive -- never create a pulse.
            if (sync) begin
                vga_h <= ~HS_ON;
            end else if (h == HS_START) begin
                vga_h <= HS_ON;
            end else if (h == HS_END) begin
                vga_h <= ~HS_ON;
            end

            if (sync) begin
                vga_v <= ~VS_ON;
            end else if ((h == HS_START) && (v == VS_START)) begin
                vga_v <= VS_ON;
            end else if ((h == HS_START) && (v == VS_END)) begin
                vga_v <= ~VS_ON;
            end

            // Colours freeze while a restart is held.
            if (!sync) begin
                vga_r <= r_n;
                vga_g <= g_n;
                vga_b <= b_n;
            end

            frame_start <= !sync && (h == 10'd0) && (v == 10'd0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Bench for vga_timing_gen. The reference model tracks only "cycles since the
// raster last restarted" and derives every expected output from that number
// with plain division/modulo arithmetic. Vertical timing of the main instance
// is shortened so whole frames fit a short run; a second instance uses a
// 400-clock line with positive sync polarity.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int HA = 512, HFP = 58, HSW = 82, HBP = 30;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VA = 8, VFP = 2, VSW = 2, VBP = 2;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int CB = 4;
    localparam int LB = 9;
    localparam int HS_A = HA + HFP;
    localparam int HS_D = HA + HFP + HSW;

    localparam int B_HA = 320, B_HFP = 16, B_HSW = 48, B_HBP = 16;
    localparam int B_HT = B_HA + B_HFP + B_HSW + B_HBP;

    logic          clk;
    logic          reset_n;
    logic          sync;
    logic          border;
    logic          scan_en;
    logic [14:0]   pixel;
    logic          vga_h, vga_v;
    logic [CB-1:0] vga_r, vga_g, vga_b;
    logic [9:0]    hcount, vcount;
    logic [LB:0]   next_pixel_x;
    logic          blank;
    logic          frame_start;

    logic          reset_n_b;
    logic          sync_b, border_b, scan_en_b;
    logic [14:0]   pixel_b;
    logic          vga_h_b, vga_v_b;
    logic [CB-1:0] vga_r_b, vga_g_b, vga_b_b;
    logic [9:0]    hcount_b, vcount_b;
    logic [9:0]    next_pixel_x_b;
    logic          blank_b;
    logic          frame_start_b;

    vga_timing_gen #(
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sync(sync), .border(border),
        .scan_en(scan_en), .pixel(pixel), .vga_h(vga_h), .vga_v(vga_v),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hcount(hcount),
        .vcount(vcount), .next_pixel_x(next_pixel_x), .blank(blank),
        .frame_start(frame_start)
    );

    vga_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HSW), .H_BP(B_HBP),
        .HS_POL(1), .VS_POL(1)
    ) dut_b (
        .clk(clk), .reset_n(reset_n_b), .sync(sync_b), .border(border_b),
        .scan_en(scan_en_b), .pixel(pixel_b), .vga_h(vga_h_b), .vga_v(vga_v_b),
        .vga_r(vga_r_b), .vga_g(vga_g_b), .vga_b(vga_b_b), .hcount(hcount_b),
        .vcount(vcount_b), .next_pixel_x(next_pixel_x_b), .blank(blank_b),
        .frame_start(frame_start_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int            n_checks;
    int            n_fail;
    int            mt;      // cycles since main instance restarted
    int            mt_b;    // cycles since second instance left reset
    logic [CB-1:0] exp_r, exp_g, exp_b;
    logic          exp_fs;

    function automatic logic [CB-1:0] chan(int f5, int hh, int vv, logic sc, logic bd);
        int c;
        c = f5 >> (5 - CB);
        if (sc && (vv % 2 == 1)) c = c / 2;
        if (bd && (hh == 0 || hh == HA - 1 || vv == 0 || vv == VA - 1)) c = (1 << CB) - 1;
        if (hh >= HA || vv >= VA) c = 0;
        return CB'(c);
    endfunction

    // Sync outputs are registered, so they show the match of the cycle before.
    function automatic logic exp_hs(int t);
        int hh;
        hh = t % HT;
        return (hh > HS_A && hh <= HS_D) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic exp_vs(int t);
        int p;
        p = t % FRAME;
        return (p > (VA + VFP) * HT + HS_A && p <= (VA + VFP + VSW) * HT + HS_A) ? 1'b0 : 1'b1;
    endfunction

    // Buffer half = parity of lines completed since restart.
    function automatic logic [LB:0] exp_npx(int t, logic s);
        int n;
        if (s) return '0;
        n = t + 1;
        return 10'((((n / HT) % 2) << LB) | ((n % HT) % (1 << LB)));
    endfunction

    // Advance the model over one clock edge using the current inputs, then
    // step the DUT and sample 1 ns after the edge.
    task automatic tick();
        int h0, v0;
        h0 = mt % HT;
        v0 = (mt / HT) % VT;
        exp_fs = !sync && h0 == 0 && v0 == 0;
        if (!sync) begin
            exp_r = chan(int'(pixel[4:0]), h0, v0, scan_en, border);
            exp_g = chan(int'(pixel[9:5]), h0, v0, scan_en, border);
            exp_b = chan(int'(pixel[14:10]), h0, v0, scan_en, border);
        end
        mt = sync ? 0 : mt + 1;
        mt_b = mt_b + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(int hh, int vv);
        for (int i = 0; i < FRAME + 1; i++) begin
            if (mt % HT == hh && (mt / HT) % VT == vv) break;
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        reset_n_b = 1'b0;
        sync = 1'b0; border = 1'b0; scan_en = 1'b0; pixel = 15'h7FFF;
        sync_b = 1'b0; border_b = 1'b0; scan_en_b = 1'b0; pixel_b = 15'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (hcount !== 10'd0 || vcount !== 10'd0) begin n_fail++; $display("FAIL reset_counters: got h=%0d v=%0d expected 0 0", hcount, vcount); end
        n_checks++; if (vga_h !== 1'b1 || vga_v !== 1'b1) begin n_fail++; $display("FAIL reset_syncs: got h=%b v=%b expected 1 1", vga_h, vga_v); end
        n_checks++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin n_fail++; $display("FAIL reset_colour: got %h expected 000", {vga_r, vga_g, vga_b}); end
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
        n_checks++; if (next_pixel_x !== 10'd1) begin n_fail++; $display("FAIL reset_npx: got %0d expected 1", next_pixel_x); end
        n_checks++; if (blank !== 1'b0) begin n_fail++; $display("FAIL reset_blank: got %b expected 0", blank); end
        n_checks++; if (vga_h_b !== 1'b0 || vga_v_b !== 1'b0) begin n_fail++; $display("FAIL reset_pol_syncs: got h=%b v=%b expected 0 0", vga_h_b, vga_v_b); end
        @(negedge clk);
        reset_n = 1'b1;
        reset_n_b = 1'b1;
        mt = 0; mt_b = 0;
        exp_r = '0; exp_g = '0; exp_b = '0; exp_fs = 1'b0;
    endtask

    task automatic test_free_run(int cycles, bit rnd_sync);
        int   h_e, v_e;
        int   hs_low, vs_low, fs_cnt;
        int   last_hs_fall, last_vs_fall, last_fs;
        logic prev_h, prev_v;
        hs_low = 0; vs_low = 0; fs_cnt = 0;
        last_hs_fall = -1; last_vs_fall = -1; last_fs = -1;
        prev_h = vga_h; prev_v = vga_v;
        for (int i = 0; i < cycles; i++) begin
            pixel   = 15'($urandom);
            border  = ($urandom_range(0, 3) == 0);
            scan_en = 1'($urandom_range(0, 1));
            sync    = rnd_sync ? ($urandom_range(0, 499) == 0) : 1'b0;
            tick();
            h_e = mt % HT;
            v_e = (mt / HT) % VT;
            n_checks++; if (hcount !== 10'(h_e)) begin n_fail++; $display("FAIL run_hcount: got %0d expected %0d", hcount, h_e); end
            n_checks++; if (vcount !== 10'(v_e)) begin n_fail++; $display("FAIL run_vcount: got %0d expected %0d", vcount, v_e); end
            n_checks++; if (blank !== (h_e >= HA || v_e >= VA)) begin n_fail++; $display("FAIL run_blank: got %b at h=%0d v=%0d", blank, h_e, v_e); end
            n_checks++; if (vga_h !== exp_hs(mt)) begin n_fail++; $display("FAIL run_hsync: got %b expected %b at h=%0d", vga_h, exp_hs(mt), h_e); end
            n_checks++; if (vga_v !== exp_vs(mt)) begin n_fail++; $display("FAIL run_vsync: got %b expected %b at h=%0d v=%0d", vga_v, exp_vs(mt), h_e, v_e); end
            n_checks++; if ({vga_r, vga_g, vga_b} !== {exp_r, exp_g, exp_b}) begin n_fail++; $display("FAIL run_colour: got %h expected %h at h=%0d v=%0d", {vga_r, vga_g, vga_b}, {exp_r, exp_g, exp_b}, h_e, v_e); end
            n_checks++; if (frame_start !== exp_fs) begin n_fail++; $display("FAIL run_fs: got %b expected %b", frame_start, exp_fs); end
            n_checks++; if (next_pixel_x !== exp_npx(mt, sync)) begin n_fail++; $display("FAIL run_npx: got %h expected %h", next_pixel_x, exp_npx(mt, sync)); end
            if (!rnd_sync) begin
                if (prev_h && !vga_h) begin
                    if (last_hs_fall >= 0) begin
                        n_checks++; if (i - last_hs_fall != HT) begin n_fail++; $display("FAIL hsync_period: got %0d expected %0d", i - last_hs_fall, HT); end
                    end
                    last_hs_fall = i;
                end
                if (!vga_h) hs_low++;
                if (!prev_h && vga_h) begin
                    n_checks++; if (hs_low != HSW) begin n_fail++; $display("FAIL hsync_width: got %0d expected %0d", hs_low, HSW); end
                    hs_low = 0;
                end
                if (prev_v && !vga_v) begin
                    if (last_vs_fall >= 0) begin
                        n_checks++; if (i - last_vs_fall != FRAME) begin n_fail++; $display("FAIL vsync_period: got %0d expected %0d", i - last_vs_fall, FRAME); end
                    end
                    last_vs_fall = i;
                end
                if (!vga_v) vs_low++;
                if (!prev_v && vga_v) begin
                    n_checks++; if (vs_low != VSW * HT) begin n_fail++; $display("FAIL vsync_width: got %0d expected %0d", vs_low, VSW * HT); end
                    vs_low = 0;
                end
                if (frame_start) begin
                    fs_cnt++;
                    if (last_fs >= 0) begin
                        n_checks++; if (i - last_fs != FRAME) begin n_fail++; $display("FAIL fs_period: got %0d expected %0d", i - last_fs, FRAME); end
                    end
                    last_fs = i;
                end
            end
            prev_h = vga_h;
            prev_v = vga_v;
        end
        sync = 1'b0;
        if (!rnd_sync) begin
            n_checks++; if (fs_cnt != cycles / FRAME) begin n_fail++; $display("FAIL fs_count: got %0d expected %0d", fs_cnt, cycles / FRAME); end
        end
    endtask

    task automatic test_border();
        int          bh[7];
        int          bv[7];
        logic [11:0] bexp[7];
        bh = '{101, 101, 1, 2, 512, 513, 101};
        bv = '{0, 1, 5, 5, 5, 5, VA - 1};
        bexp = '{12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF};
        pixel = 15'h0; border = 1'b1; scan_en = 1'b0; sync = 1'b0;
        for (int k = 0; k < 7; k++) begin
            run_to(bh[k], bv[k]);
            n_checks++; if ({vga_r, vga_g, vga_b} !== bexp[k]) begin n_fail++; $display("FAIL border_%0d: got %h expected %h (colour of h=%0d v=%0d)", k, {vga_r, vga_g, vga_b}, bexp[k], bh[k] - 1, bv[k]); end
        end
    endtask

    task automatic test_colour();
        pixel = 15'h7FFF; border = 1'b0; scan_en = 1'b1; sync = 1'b0;
        run_to(10, 0);
        n_checks++; if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin n_fail++; $display("FAIL colour_line0: got %h expected fff", {vga_r, vga_g, vga_b}); end
        run_to(0, 1);
        n_checks++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin n_fail++; $display("FAIL colour_lag: got %h expected 000", {vga_r, vga_g, vga_b}); end
        run_to(1, 1);
        n_checks++; if ({vga_r, vga_g, vga_b} !== 12'h777) begin n_fail++; $display("FAIL colour_line1: got %h expected 777", {vga_r, vga_g, vga_b}); end
        run_to(600, 1);
        n_checks++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin n_fail++; $display("FAIL colour_blank: got %h expected 000", {vga_r, vga_g, vga_b}); end
        run_to(1, 2);
        n_checks++; if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin n_fail++; $display("FAIL colour_line2: got %h expected fff", {vga_r, vga_g, vga_b}); end
    endtask

    task automatic test_pingpong();
        int          par;
        logic [LB:0] want;
        sync = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < HT; i++) begin
                if (mt % HT == HT - 1) break;
                tick();
            end
            par = (mt / HT) % 2;
            want = 10'((par ^ 1) << LB);
            n_checks++; if (next_pixel_x !== want) begin n_fail++; $display("FAIL pp_hend_%0d: got %h expected %h", k, next_pixel_x, want); end
            tick();
            want = 10'((((mt / HT) % 2) << LB) | 1);
            n_checks++; if (next_pixel_x !== want) begin n_fail++; $display("FAIL pp_line_start_%0d: got %h expected %h", k, next_pixel_x, want); end
        end
        for (int i = 0; i < 2 * HT; i++) begin
            if (mt % HT == 200 && (mt / HT) % 2 == 1) break;
            tick();
        end
        n_checks++; if (next_pixel_x !== 10'h200 + 10'd201) begin n_fail++; $display("FAIL pp_odd_line: got %h expected %h", next_pixel_x, 10'h200 + 10'd201); end
        sync = 1'b1;
        #1;
        n_checks++; if (next_pixel_x !== 10'd0) begin n_fail++; $display("FAIL pp_sync_msb: got %h expected 000", next_pixel_x); end
        tick();
        sync = 1'b0;
        #1;
        n_checks++; if (next_pixel_x !== 10'd1) begin n_fail++; $display("FAIL pp_after_sync: got %h expected 001", next_pixel_x); end
    endtask

    task automatic test_sync_pulse();
        sync = 1'b0;
        run_to(300, 6);
        n_checks++; if (vga_h !== 1'b1) begin n_fail++; $display("FAIL sp_pre_hsync: got %b expected 1", vga_h); end
        sync = 1'b1;
        tick();
        n_checks++; if (hcount !== 10'd0 || vcount !== 10'd0) begin n_fail++; $display("FAIL sp_counters: got h=%0d v=%0d expected 0 0", hcount, vcount); end
        n_checks++; if (next_pixel_x !== 10'd0) begin n_fail++; $display("FAIL sp_npx: got %h expected 000", next_pixel_x); end
        n_checks++; if (vga_h !== 1'b1 || vga_v !== 1'b1) begin n_fail++; $display("FAIL sp_no_glitch: got h=%b v=%b expected 1 1", vga_h, vga_v); end
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL sp_fs_during: got %b expected 0", frame_start); end
        sync = 1'b0;
        tick();
        n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL sp_fs_after: got %b expected 1", frame_start); end
        n_checks++; if (hcount !== 10'd1 || vga_h !== 1'b1) begin n_fail++; $display("FAIL sp_resume: got h=%0d hsync=%b expected 1 1", hcount, vga_h); end
        tick();
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL sp_fs_single: got %b expected 0", frame_start); end
    endtask

    task automatic test_sync_hold();
        int n;
        n = $urandom_range(50, 500);
        for (int i = 0; i < n; i++) tick();
        sync = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++; if (hcount !== 10'd0 || vcount !== 10'd0 || frame_start !== 1'b0) begin n_fail++; $display("FAIL hold_%0d: got h=%0d v=%0d fs=%b expected 0 0 0", i, hcount, vcount, frame_start); end
        end
        sync = 1'b0;
        tick();
        n_checks++; if (frame_start !== 1'b1 || hcount !== 10'd1) begin n_fail++; $display("FAIL hold_release: got fs=%b h=%0d expected 1 1", frame_start, hcount); end
    endtask

    task automatic test_reset_mid_frame();
        pixel = 15'h7FFF; border = 1'b0; scan_en = 1'b0; sync = 1'b0;
        run_to(200, 5);
        n_checks++; if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin n_fail++; $display("FAIL rmf_pre_colour: got %h expected fff", {vga_r, vga_g, vga_b}); end
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++; if (hcount !== 10'd0 || vcount !== 10'd0) begin n_fail++; $display("FAIL rmf_counters: got h=%0d v=%0d expected 0 0", hcount, vcount); end
        n_checks++; if ({vga_r, vga_g, vga_b} !== 12'h000 || frame_start !== 1'b0) begin n_fail++; $display("FAIL rmf_outputs: got colour=%h fs=%b expected 000 0", {vga_r, vga_g, vga_b}, frame_start); end
        n_checks++; if (vga_h !== 1'b1 || vga_v !== 1'b1) begin n_fail++; $display("FAIL rmf_syncs: got h=%b v=%b expected 1 1", vga_h, vga_v); end
        #1;
        reset_n = 1'b1;
        mt = 0;
        exp_r = '0; exp_g = '0; exp_b = '0; exp_fs = 1'b0;
        tick();
        n_checks++; if (hcount !== 10'd1 || frame_start !== 1'b1) begin n_fail++; $display("FAIL rmf_restart: got h=%0d fs=%b expected 1 1", hcount, frame_start); end
        n_checks++; if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin n_fail++; $display("FAIL rmf_colour: got %h expected fff", {vga_r, vga_g, vga_b}); end
    endtask

    task automatic test_polarity();
        int   hb, high, last_rise;
        logic want, prev;
        high = 0; last_rise = -1; prev = vga_h_b;
        for (int i = 0; i < 3 * B_HT; i++) begin
            tick();
            hb = mt_b % B_HT;
            want = (hb >= B_HA + B_HFP + 1 && hb <= B_HA + B_HFP + B_HSW);
            n_checks++; if (vga_h_b !== want) begin n_fail++; $display("FAIL pol_hsync: got %b expected %b at h=%0d", vga_h_b, want, hb); end
            n_checks++; if (hcount_b !== 10'(hb)) begin n_fail++; $display("FAIL pol_hcount: got %0d expected %0d", hcount_b, hb); end
            if (!prev && vga_h_b) begin
                if (last_rise >= 0) begin
                    n_checks++; if (i - last_rise != B_HT) begin n_fail++; $display("FAIL pol_period: got %0d expected %0d", i - last_rise, B_HT); end
                end
                last_rise = i;
            end
            if (vga_h_b) high++;
            if (prev && !vga_h_b) begin
                n_checks++; if (high != B_HSW) begin n_fail++; $display("FAIL pol_width: got %0d expected %0d", high, B_HSW); end
                high = 0;
            end
            prev = vga_h_b;
        end
        for (int i = 0; i < B_HT; i++) begin
            if (mt_b % B_HT == 350) break;
            tick();
        end
        n_checks++; if (vga_h_b !== 1'b1) begin n_fail++; $display("FAIL pol_pre_reset: got %b expected 1", vga_h_b); end
        #1;
        reset_n_b = 1'b0;
        #1;
        n_checks++; if (vga_h_b !== 1'b0 || hcount_b !== 10'd0) begin n_fail++; $display("FAIL pol_async_reset: got hsync=%b h=%0d expected 0 0", vga_h_b, hcount_b); end
        #1;
        reset_n_b = 1'b1;
        mt_b = 0;
        tick();
        n_checks++; if (hcount_b !== 10'd1 || vga_h_b !== 1'b0) begin n_fail++; $display("FAIL pol_restart: got h=%0d hsync=%b expected 1 0", hcount_b, vga_h_b); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_fail = 0;
        mt = 0;
        mt_b = 0;
        test_reset();
        test_free_run(2 * FRAME, 1'b0);
        test_border();
        test_colour();
        test_pingpong();
        test_sync_pulse();
        test_sync_hold();
        test_free_run(4000, 1'b1);
        test_reset_mid_frame();
        test_polarity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
